decoder_2to4_stretch: RTL and testbench



---
 rtl/decoder_2to4_stretch.sv | 91 +++++++++
 tb/tb_decoder_2to4_stretch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_2to4_stretch.sv
// rtl/decoder_2to4_stretch.sv - registered 2-to-4 decoder with per-code hold stretch and saturating line counters
module decoder_2to4_stretch #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       in_code,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr_counts,
    output logic [3:0]       out_onehot,
    output logic             out_active,
    output logic [CNT_W-1:0] count_d0,
    output logic [CNT_W-1:0] count_d1,
    output logic [CNT_W-1:0] count_d2,
    output logic [CNT_W-1:0] count_d3
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [HW-1:0]    hold_cnt;
    logic [CNT_W-1:0] cnt [4];
    logic             xfer;

    // in_ready depends on registers only, so upstream sees no combinational loop
    assign in_ready = (state == IDLE) || (hold_cnt == '0);
    assign xfer     = in_valid && in_ready;

    // The registered one-hot line doubles as the stored code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            out_onehot <= 4'b0000;
            out_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        state      <= HOLD;
                        hold_cnt   <= HOLD_LAST;
                        out_onehot <= 4'b0001 << in_code;
                        out_active <= 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end else if (xfer) begin
                        hold_cnt   <= HOLD_LAST;
                        out_onehot <= 4'b0001 << in_code;
                    end else begin
                        state      <= IDLE;
                        out_onehot <= 4'b0000;
                        out_active <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    out_onehot <= 4'b0000;
                    out_active <= 1'b0;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle transfer increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (clr_counts) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (xfer && (cnt[in_code] != '1)) begin
            cnt[in_code] <= cnt[in_code] + CNT_W'(1);
        end
    end

    assign count_d0 = cnt[0];
    assign count_d1 = cnt[1];
    assign count_d2 = cnt[2];
    assign count_d3 = cnt[3];

endmodule

// File: tb/tb_decoder_2to4_stretch.sv
// tb/tb_decoder_2to4_stretch.sv - schedule-model bench for decoder_2to4_stretch (HOLD=4/CNT_W=2 and HOLD=1/CNT_W=8)
module tb_decoder_2to4_stretch;

    localparam int NC = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] code_a = 2'd0, code_b = 2'd0;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic       clr_a = 1'b0, clr_b = 1'b0;

    logic       rdy_a, act_a, rdy_b, act_b;
    logic [3:0] oh_a, oh_b;
    logic [1:0] c0_a, c1_a, c2_a, c3_a;
    logic [7:0] c0_b, c1_b, c2_b, c3_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected one-hot per cycle index, booked HOLD cycles ahead at each accepted code
    logic [3:0] sched [2][NC];
    int         cnt   [2][4];
    int         hold_len [2] = '{4, 1};
    int         cmax     [2] = '{3, 255};
    logic [3:0] lit      [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    decoder_2to4_stretch #(.HOLD_CYCLES(4), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .in_code(code_a), .in_valid(valid_a), .in_ready(rdy_a),
        .clr_counts(clr_a), .out_onehot(oh_a), .out_active(act_a),
        .count_d0(c0_a), .count_d1(c1_a), .count_d2(c2_a), .count_d3(c3_a)
    );

    decoder_2to4_stretch #(.HOLD_CYCLES(1), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_code(code_b), .in_valid(valid_b), .in_ready(rdy_b),
        .clr_counts(clr_b), .out_onehot(oh_b), .out_active(act_b),
        .count_d0(c0_b), .count_d1(c1_b), .count_d2(c2_b), .count_d3(c3_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NC; i++) sched[k][i] = 4'd0;
            for (int i = 0; i < 4; i++) cnt[k][i] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic v, input logic [1:0] c, input logic clr);
        if (cyc < NC && v && sched[k][cyc] == 4'd0) begin
            for (int i = 0; i < hold_len[k]; i++)
                if (cyc + i < NC) sched[k][cyc + i] = 4'b0001 << c;
            if (cnt[k][c] < cmax[k]) cnt[k][c]++;
        end
        if (clr)
            for (int i = 0; i < 4; i++) cnt[k][i] = 0;
    endtask

    task automatic model_cmp(input int k, input logic [3:0] oh, input logic act, input logic rdy,
                             input int n0, input int n1, input int n2, input int n3);
        string p;
        int    e_oh;
        int    e_rdy;
        p     = (k == 0) ? "a" : "b";
        e_oh  = (cyc < NC) ? int'(sched[k][cyc]) : 0;
        e_rdy = (cyc + 1 < NC) ? int'(sched[k][cyc + 1] == 4'd0) : 1;
        check($sformatf("%s_onehot", p), int'(oh), e_oh);
        check($sformatf("%s_active", p), int'(act), int'(e_oh != 0));
        check($sformatf("%s_ready", p), int'(rdy), e_rdy);
        check($sformatf("%s_count_d0", p), n0, cnt[k][0]);
        check($sformatf("%s_count_d1", p), n1, cnt[k][1]);
        check($sformatf("%s_count_d2", p), n2, cnt[k][2]);
        check($sformatf("%s_count_d3", p), n3, cnt[k][3]);
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            model_step(0, valid_a, code_a, clr_a);
            model_step(1, valid_b, code_b, clr_b);
        end
        #1;
        if (!rst) begin
            model_cmp(0, oh_a, act_a, rdy_a, int'(c0_a), int'(c1_a), int'(c2_a), int'(c3_a));
            model_cmp(1, oh_b, act_b, rdy_b, int'(c0_b), int'(c1_b), int'(c2_b), int'(c3_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        #1 rst = 1'b1;
        #1;
        check("reset_onehot", int'(oh_a), 0);
        check("reset_ready", int'(rdy_a), 1);
        check("reset_active", int'(act_a), 0);
        check("reset_count_d3", int'(c3_a), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single codes with idle gaps
        for (int c = 0; c < 4; c++) begin
            code_a = 2'(c);
            valid_a = 1'b1;
            tick();
            valid_a = 1'b0;
            for (int j = 0; j < 4; j++) begin
                check("single_line", int'(oh_a), int'(lit[c]));
                tick();
            end
            check("single_gap", int'(oh_a), 0);
            tick();
        end
        check("single_cnt_d0", int'(c0_a), 1);
        check("single_cnt_d1", int'(c1_a), 1);
        check("single_cnt_d2", int'(c2_a), 1);
        check("single_cnt_d3", int'(c3_a), 1);

        // back-to-back 2 then 1
        code_a = 2'd2;
        valid_a = 1'b1;
        tick();
        code_a = 2'd1;
        for (int j = 0; j < 4; j++) begin
            check("b2b_first", int'(oh_a), 4'b0100);
            check("b2b_ready", int'(rdy_a), (j == 3) ? 1 : 0);
            tick();
        end
        valid_a = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check("b2b_second", int'(oh_a), 4'b0010);
            tick();
        end
        check("b2b_end", int'(oh_a), 0);
        tick();
        check("b2b_cnt_d2", int'(c2_a), 2);
        check("b2b_cnt_d1", int'(c1_a), 2);

        // input ignored while busy, including a lost single-cycle pulse
        code_a = 2'd3;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        code_a = 2'd0;
        tick();
        valid_a = 1'b1;
        code_a = 2'd1;
        tick();
        valid_a = 1'b0;
        code_a = 2'd2;
        check("ignore_line", int'(oh_a), 4'b1000);
        tick();
        check("ignore_line2", int'(oh_a), 4'b1000);
        tick();
        check("ignore_end", int'(oh_a), 0);
        check("ignore_cnt_d3", int'(c3_a), 2);
        check("ignore_cnt_d0", int'(c0_a), 1);
        check("ignore_cnt_d1", int'(c1_a), 2);

        // saturation at 3 with CNT_W=2
        code_a = 2'd3;
        valid_a = 1'b1;
        repeat (20) tick();
        valid_a = 1'b0;
        tick();
        tick();
        check("sat_cnt_d3", int'(c3_a), 3);
        check("sat_idle", int'(oh_a), 0);

        // clear together with a transfer
        code_a = 2'd3;
        valid_a = 1'b1;
        clr_a = 1'b1;
        tick();
        valid_a = 1'b0;
        clr_a = 1'b0;
        check("clr_cnt_d3", int'(c3_a), 0);
        check("clr_cnt_d1", int'(c1_a), 0);
        for (int j = 0; j < 4; j++) begin
            check("clr_line", int'(oh_a), 4'b1000);
            tick();
        end
        check("clr_end", int'(oh_a), 0);
        check("clr_cnt_d3_after", int'(c3_a), 0);

        // asynchronous reset in the middle of a hold
        code_a = 2'd1;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        tick();
        check("pre_rst_line", int'(oh_a), 4'b0010);
        check("pre_rst_cnt_d1", int'(c1_a), 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_onehot", int'(oh_a), 0);
        check("midrst_active", int'(act_a), 0);
        check("midrst_ready", int'(rdy_a), 1);
        check("midrst_cnt_d1", int'(c1_a), 0);
        clear_model();
        tick();
        rst = 1'b0;
        tick();
        check("postrst_onehot", int'(oh_a), 0);
        check("postrst_cnt_d1", int'(c1_a), 0);

        // HOLD_CYCLES=1 stream
        code_b = 2'd0;
        valid_b = 1'b1;
        tick();
        check("h1_line0", int'(oh_b), 4'b0001);
        check("h1_ready0", int'(rdy_b), 1);
        code_b = 2'd3;
        tick();
        check("h1_line1", int'(oh_b), 4'b1000);
        check("h1_ready1", int'(rdy_b), 1);
        code_b = 2'd0;
        tick();
        check("h1_line2", int'(oh_b), 4'b0001);
        check("h1_ready2", int'(rdy_b), 1);
        valid_b = 1'b0;
        tick();
        check("h1_end", int'(oh_b), 0);
        check("h1_ready3", int'(rdy_b), 1);
        check("h1_cnt_d0", int'(c0_b), 2);
        check("h1_cnt_d3", int'(c3_b), 1);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
